// File: rtl/enc_decoder.sv
// Rebuilds the one-hot line vector from {a2,a1,a0}/none and queues it; a put is visible on get one cycle later.
// Backpressure via RDY_put/RDY_get from registered occupancy only; enables while not ready are dropped and latch mv_err.

module enc_decoder_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_vld,
  input  logic [W-1:0]  push_dat,
  output logic          push_rdy,
  input  logic          pop_vld,
  output logic          pop_rdy,
  output logic [W-1:0]  pop_dat,
  output logic [CW-1:0] count
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic          push_acc;
  logic          pop_acc;

  assign push_rdy = (count != CW'(DEPTH));
  assign pop_rdy  = (count != '0);
  assign push_acc = push_vld && push_rdy;
  assign pop_acc  = pop_vld && pop_rdy;

  // Head is masked while empty so storage needs no reset.
  assign pop_dat  = pop_rdy ? mem[rp] : '0;

  always_ff @(posedge clk) begin
    if (push_acc) begin
      mem[wp] <= push_dat;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (push_acc) begin
        wp <= wp + AW'(1);
      end
      if (pop_acc) begin
        rp <= rp + AW'(1);
      end
      case ({push_acc, pop_acc})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

module enc_decoder #(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          EN_put,
  input  logic [2:0]    put_code,
  input  logic          put_none,
  output logic          RDY_put,
  input  logic          EN_get,
  output logic [7:0]    get,
  output logic          RDY_get,
  output logic [CW-1:0] mv_count,
  output logic          mv_err
);
  logic [7:0] dec_dat;

  assign dec_dat = put_none ? 8'h00 : (8'h01 << put_code);

  enc_decoder_fifo #(
    .W     (8),
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk      (CLK),
    .rst      (RST),
    .push_vld (EN_put),
    .push_dat (dec_dat),
    .push_rdy (RDY_put),
    .pop_vld  (EN_get),
    .pop_rdy  (RDY_get),
    .pop_dat  (get),
    .count    (mv_count)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      mv_err <= 1'b0;
    end else if ((EN_put && !RDY_put) || (EN_get && !RDY_get)) begin
      mv_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_enc_decoder.sv
// Random and directed bench for enc_decoder against a queue-based model.
module tb_enc_decoder;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          CLK;
  logic          RST;
  logic          EN_put;
  logic [2:0]    put_code;
  logic          put_none;
  logic          RDY_put;
  logic          EN_get;
  logic [7:0]    get;
  logic          RDY_get;
  logic [CW-1:0] mv_count;
  logic          mv_err;

  enc_decoder #(.DEPTH(DEPTH)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .EN_put   (EN_put),
    .put_code (put_code),
    .put_none (put_none),
    .RDY_put  (RDY_put),
    .EN_get   (EN_get),
    .get      (get),
    .RDY_get  (RDY_get),
    .mv_count (mv_count),
    .mv_err   (mv_err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] q[$];
  bit         m_err;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".get"},      32'(get),      (q.size() != 0) ? 32'(q[0]) : 32'h0);
    check({tag, ".RDY_put"},  32'(RDY_put),  32'(q.size() < DEPTH));
    check({tag, ".RDY_get"},  32'(RDY_get),  32'(q.size() > 0));
    check({tag, ".mv_count"}, 32'(mv_count), 32'(q.size()));
    check({tag, ".mv_err"},   32'(mv_err),   32'(m_err));
  endtask

  // One clock: drive enables, let the model take the edge, then compare at the falling edge.
  task automatic step(input string tag, input logic ep, input logic [2:0] c,
                      input logic n, input logic eg);
    bit put_ok;
    bit get_ok;
    EN_put   = ep;
    put_code = c;
    put_none = n;
    EN_get   = eg;
    put_ok   = ep && (q.size() < DEPTH);
    get_ok   = eg && (q.size() > 0);
    @(posedge CLK);
    if ((ep && !put_ok) || (eg && !get_ok)) m_err = 1'b1;
    if (get_ok) void'(q.pop_front());
    if (put_ok) q.push_back(n ? 8'h00 : 8'(2 ** int'(c)));
    @(negedge CLK);
    EN_put = 1'b0;
    EN_get = 1'b0;
    check_all(tag);
  endtask

  task automatic do_reset_pulse();
    #2 RST = 1'b1;
    q.delete();
    m_err = 1'b0;
    #1 check_all("rst_pulse");
    RST = 1'b0;
  endtask

  initial begin
    RST      = 1'b1;
    EN_put   = 1'b0;
    EN_get   = 1'b0;
    put_code = 3'd0;
    put_none = 1'b0;
    m_err    = 1'b0;

    #2;
    check_all("reset");
    @(negedge CLK);
    RST = 1'b0;

    // Decode order
    step("ord_p7", 1, 3'd7, 0, 0);
    step("ord_p5", 1, 3'd5, 0, 0);
    step("ord_p0", 1, 3'd0, 0, 0);
    check("ord_head", 32'(get), 32'h80);
    step("ord_g1", 0, 3'd0, 0, 1);
    check("ord_2nd", 32'(get), 32'h20);
    step("ord_g2", 0, 3'd0, 0, 1);
    check("ord_3rd", 32'(get), 32'h01);
    step("ord_g3", 0, 3'd0, 0, 1);
    check("ord_empty", 32'(RDY_get), 32'h0);

    // None flag
    step("none_p", 1, 3'd3, 1, 0);
    check("none_get", 32'(get), 32'h00);
    check("none_rdy", 32'(RDY_get), 32'h1);
    step("none_g", 0, 3'd0, 0, 1);

    // Full / overflow
    for (int i = 1; i <= 4; i++) step("full_p", 1, 3'(i), 0, 0);
    step("ovf_p6", 1, 3'd6, 0, 0);
    check("ovf_err", 32'(mv_err), 32'h1);
    check("ovf_rdy", 32'(RDY_put), 32'h0);
    for (int i = 0; i < 4; i++) begin
      check("ovf_drain", 32'(get), 32'(8'h02 << i));
      step("ovf_g", 0, 3'd0, 0, 1);
    end

    // Simultaneous put/get across pointer wrap, with a clean error flag
    do_reset_pulse();
    @(negedge CLK);
    step("sim_fill", 1, 3'd6, 0, 0);
    step("sim_fill", 1, 3'd7, 0, 0);
    for (int i = 0; i < 10; i++) step("sim_pg", 1, 3'(i % 8), 0, 1);
    check("sim_err", 32'(mv_err), 32'h0);

    // Full with put+get, then empty with put+get
    step("fb_p", 1, 3'd1, 0, 0);
    step("fb_p", 1, 3'd2, 0, 0);
    step("fb_both", 1, 3'd4, 0, 1);
    do_reset_pulse();
    @(negedge CLK);
    step("eb_both", 1, 3'd5, 0, 1);
    check("eb_cnt", 32'(mv_count), 32'h1);

    // Reset mid-stream with count=3 and error set
    step("rm_p", 1, 3'd1, 0, 0);
    step("rm_p", 1, 3'd2, 0, 0);
    check("rm_cnt", 32'(mv_count), 32'h3);
    do_reset_pulse();
    check("rm_get0", 32'(get), 32'h0);
    @(negedge CLK);
    step("rm_p2", 1, 3'd2, 0, 0);
    check("rm_get4", 32'(get), 32'h04);

    // Random traffic, illegal enables included
    for (int i = 0; i < 400; i++) begin
      step("rnd", 1'($urandom_range(0, 99) < 55), 3'($urandom), 1'($urandom_range(0, 9) == 0),
           1'($urandom_range(0, 99) < 50));
      if ($urandom_range(0, 99) == 0) do_reset_pulse();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
